// File: rtl/fpu_pkg.sv
// Shared encodings for the scalar half-precision FPU issue path: sfpu opcode bit
// indices, fflags bit positions, sequencer states and the integer-destination op set.
package fpu_pkg;

  localparam int unsigned SFPU_W = 24;

  localparam int unsigned OP_FADD     = 0;
  localparam int unsigned OP_FSUB     = 1;
  localparam int unsigned OP_FMUL     = 2;
  localparam int unsigned OP_FDIV     = 3;
  localparam int unsigned OP_FSQRT    = 4;
  localparam int unsigned OP_FMADD    = 5;
  localparam int unsigned OP_FMSUB    = 6;
  localparam int unsigned OP_FMV_X_H  = 7;
  localparam int unsigned OP_FMV_H_X  = 8;
  localparam int unsigned OP_FEQ      = 9;
  localparam int unsigned OP_FLT      = 10;
  localparam int unsigned OP_FLE      = 11;
  localparam int unsigned OP_FMIN     = 12;
  localparam int unsigned OP_FMAX     = 13;
  localparam int unsigned OP_FCVT_W_H = 14;
  localparam int unsigned OP_FCVT_H_W = 15;
  localparam int unsigned OP_FSGNJ    = 16;
  localparam int unsigned OP_FSGNJN   = 17;
  localparam int unsigned OP_FSGNJX   = 18;
  localparam int unsigned OP_FNMADD   = 19;
  localparam int unsigned OP_FNMSUB   = 20;
  localparam int unsigned OP_FCLASS   = 21;
  localparam int unsigned OP_LAST     = OP_FCLASS;
  localparam int unsigned OP_UNSIGNED = 22;
  localparam int unsigned OP_SIGNED   = 23;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  // Ops whose result is written to the integer register file.
  localparam logic [OP_LAST:0] INT_DEST_MASK =
      (22'd1 << OP_FMV_X_H)  | (22'd1 << OP_FEQ) | (22'd1 << OP_FLT) |
      (22'd1 << OP_FLE)      | (22'd1 << OP_FCVT_W_H) | (22'd1 << OP_FCLASS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPT,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/fpu_op_encode.sv
// Combinational opcode decoder: index to sfpu one-hot (with signedness bit for the
// integer conversions), integer-destination flag and illegal-opcode flag.
module fpu_op_encode
  import fpu_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0]    op_i,
  input  logic              unsigned_i,
  output logic [SFPU_W-1:0] sfpu_op_o,
  output logic              int_dest_o,
  output logic              illegal_o
);

  always_comb begin
    sfpu_op_o  = '0;
    int_dest_o = 1'b0;
    illegal_o  = 1'b1;
    for (int unsigned i = 0; i <= OP_LAST; i++) begin
      if (op_i == OPW'(i)) begin
        sfpu_op_o[i] = 1'b1;
        int_dest_o   = INT_DEST_MASK[i];
        illegal_o    = 1'b0;
      end
    end
    if (op_i == OPW'(OP_FCVT_W_H) || op_i == OPW'(OP_FCVT_H_W)) begin
      if (unsigned_i) sfpu_op_o[OP_UNSIGNED] = 1'b1;
      else            sfpu_op_o[OP_SIGNED]   = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_issue_seq.sv
// Issue/writeback sequencer in front of the half-precision FPU: drives one op per
// handshake, waits out the FPU latency, captures result/flags and returns a response.
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int unsigned STD     = 15,
  parameter int unsigned FPU_LAT = 2,
  parameter int unsigned OPW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPW-1:0]    req_op,
  input  logic              req_unsigned,
  input  logic [2:0]        req_frm,
  input  logic [STD:0]      req_a,
  input  logic [STD:0]      req_b,
  input  logic [STD:0]      req_c,
  input  logic [31:0]       req_int,
  input  logic [4:0]        req_rd,
  output logic [STD:0]      fpu_a,
  output logic [STD:0]      fpu_b,
  output logic [STD:0]      fpu_c,
  output logic [31:0]       fpu_int,
  output logic [2:0]        fpu_frm,
  output logic [SFPU_W-1:0] fpu_sfpu_op,
  output logic [27:0]       fpu_vfpu_op,
  output logic [2:0]        fpu_sel,
  output logic              fpu_rst_l,
  input  logic [STD:0]      fpu_res,
  input  logic [31:0]       fpu_res_rd,
  input  logic [4:0]        fpu_flags,
  input  logic              fpu_exc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_int,
  output logic [4:0]        rsp_rd,
  output logic              rsp_illegal,
  output logic [4:0]        fflags,
  input  logic              fflags_we,
  input  logic [4:0]        fflags_wdata,
  output logic              exc_pending,
  input  logic              exc_clr
);

  localparam int unsigned CNT_W = (FPU_LAT > 2) ? $clog2(FPU_LAT) : 1;

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STD:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic [31:0]       int_q, int_d;
  logic [2:0]        frm_q, frm_d;
  logic [SFPU_W-1:0] sfpu_q, sfpu_d;
  logic [4:0]        rd_q, rd_d;
  logic              int_dest_q, int_dest_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_int_q, rsp_int_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic [4:0]        fflags_q, fflags_d;
  logic              exc_q, exc_d;
  logic              fpu_rst_l_q;

  logic [SFPU_W-1:0] enc_sfpu;
  logic              enc_int;
  logic              enc_illegal;

  fpu_op_encode #(.OPW(OPW)) u_op_encode (
    .op_i       (req_op),
    .unsigned_i (req_unsigned),
    .sfpu_op_o  (enc_sfpu),
    .int_dest_o (enc_int),
    .illegal_o  (enc_illegal)
  );

  // Accepting is held off until the FPU has left reset as well.
  assign req_ready   = (state_q == ST_IDLE) && fpu_rst_l_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign fpu_c       = c_q;
  assign fpu_int     = int_q;
  assign fpu_frm     = frm_q;
  assign fpu_sfpu_op = sfpu_q;
  assign fpu_vfpu_op = '0;
  assign fpu_sel     = '0;
  assign fpu_rst_l   = fpu_rst_l_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_int     = rsp_int_q;
  assign rsp_rd      = rd_q;
  assign rsp_illegal = rsp_illegal_q;
  assign fflags      = fflags_q;
  assign exc_pending = exc_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    int_d         = int_q;
    frm_d         = frm_q;
    sfpu_d        = sfpu_q;
    rd_d          = rd_q;
    int_dest_d    = int_dest_q;
    rsp_data_d    = rsp_data_q;
    rsp_int_d     = rsp_int_q;
    rsp_illegal_d = rsp_illegal_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          rd_d = req_rd;
          if (enc_illegal) begin
            rsp_illegal_d = 1'b1;
            rsp_data_d    = '0;
            rsp_int_d     = 1'b0;
            state_d       = ST_RESP;
          end else begin
            a_d        = req_a;
            b_d        = req_b;
            c_d        = req_c;
            int_d      = req_int;
            frm_d      = req_frm;
            sfpu_d     = enc_sfpu;
            int_dest_d = enc_int;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        sfpu_d  = '0;
        cnt_d   = CNT_W'(FPU_LAT - 1);
        state_d = (FPU_LAT > 1) ? ST_WAIT : ST_CAPT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        rsp_int_d     = int_dest_q;
        rsp_data_d    = (int_dest_q && !fpu_exc) ? fpu_res_rd : 32'(fpu_res);
        rsp_illegal_d = 1'b0;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_illegal_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CSR write and capture may coincide: the write replaces, the FPU flags still accrue.
  always_comb begin
    fflags_d = fflags_we ? fflags_wdata : fflags_q;
    exc_d    = exc_clr ? 1'b0 : exc_q;
    if (state_q == ST_CAPT) begin
      fflags_d = fflags_d | fpu_flags;
      exc_d    = exc_d | fpu_exc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      int_q         <= '0;
      frm_q         <= '0;
      sfpu_q        <= '0;
      rd_q          <= '0;
      int_dest_q    <= 1'b0;
      rsp_data_q    <= '0;
      rsp_int_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
      fflags_q      <= '0;
      exc_q         <= 1'b0;
      fpu_rst_l_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      int_q         <= int_d;
      frm_q         <= frm_d;
      sfpu_q        <= sfpu_d;
      rd_q          <= rd_d;
      int_dest_q    <= int_dest_d;
      rsp_data_q    <= rsp_data_d;
      rsp_int_q     <= rsp_int_d;
      rsp_illegal_q <= rsp_illegal_d;
      fflags_q      <= fflags_d;
      exc_q         <= exc_d;
      fpu_rst_l_q   <= 1'b1;
    end
  end

endmodule
